// File: rtl/dsp_pkg.sv
// Shared constants for the DSP48A1-style slice: pipeline-stage selectors and default port widths.
package dsp_pkg;

  localparam int unsigned REG_DIRECT = 0;
  localparam int unsigned REG_PIPE   = 1;

  localparam int unsigned A_WIDTH      = 18;
  localparam int unsigned B_WIDTH      = 18;
  localparam int unsigned D_WIDTH      = 18;
  localparam int unsigned C_WIDTH      = 48;
  localparam int unsigned M_WIDTH      = 36;
  localparam int unsigned P_WIDTH      = 48;
  localparam int unsigned OPMODE_WIDTH = 8;

endpackage

// File: rtl/reg_mux.sv
// Optional pipeline stage: direct pass-through (REG=0) or one enabled, sync-reset register (REG=1).
// Define REG_MUX_ASSERT_EN to compile in simulation-only behavioural checks.
module reg_mux
  import dsp_pkg::*;
#(
  parameter int unsigned WIDTH = D_WIDTH,
  parameter int unsigned REG   = REG_DIRECT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] out
);

  if (WIDTH < 1 || WIDTH > 64) begin : g_bad_width
    $error("reg_mux: WIDTH=%0d outside legal range 1..64", WIDTH);
  end

  if (REG == REG_DIRECT) begin : g_direct
    // Control inputs are intentionally ignored on the direct path.
    logic unused_ctrl;
    assign unused_ctrl = &{1'b0, clk, rst, enable};
    assign out = D;

`ifdef REG_MUX_ASSERT_EN
    always_comb begin
      a_direct_follow : assert (out === D);
    end
`endif

  end else if (REG == REG_PIPE) begin : g_pipe
    // Reset has priority over enable; enable low holds the stored value.
    always_ff @(posedge clk) begin
      if (!rst) begin
        out <= '0;
      end else if (enable) begin
        out <= D;
      end
    end

`ifdef REG_MUX_ASSERT_EN
    a_ctrl_known : assert property (@(posedge clk) !$isunknown({rst, enable}));
    a_reset      : assert property (@(posedge clk) !rst |=> out == '0);
    a_load       : assert property (@(posedge clk) rst && enable |=> out == $past(D));
    a_hold       : assert property (@(posedge clk) rst && !enable |=> out == $past(out));
`endif

  end else begin : g_bad_reg
    $error("reg_mux: REG=%0d is illegal, must be 0 or 1", REG);
  end

endmodule

// File: tb/tb_reg_mux.sv
// Directed bench for reg_mux: one direct-mode and one registered-mode instance, WIDTH=18.
module tb_reg_mux;
  import dsp_pkg::*;

  localparam int unsigned W = 18;

  logic         clk = 1'b0;
  logic         rst0, en0, rst1, en1;
  logic [W-1:0] d0, d1, out0, out1;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  reg_mux #(.WIDTH(W), .REG(REG_DIRECT)) u_dir (
    .clk(clk), .rst(rst0), .enable(en0), .D(d0), .out(out0)
  );

  reg_mux #(.WIDTH(W), .REG(REG_PIPE)) u_pipe (
    .clk(clk), .rst(rst1), .enable(en1), .D(d1), .out(out1)
  );

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %05h expected %05h", tag, got, exp);
    end
  endtask

  // Drive between edges, observe 1 ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [W-1:0] dir_d  [5] = '{18'h00000, 18'h3FFFF, 18'h2A5A5, 18'h15555, 18'h00123};
  logic         dir_en [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
  logic [W-1:0] dir2_d [5] = '{18'h00001, 18'h20000, 18'h0F0F0, 18'h3C3C3, 18'h12345};

  initial begin
    rst0 = 1'b0; en0 = 1'b0; d0 = '0;
    rst1 = 1'b0; en1 = 1'b0; d1 = '0;

    // Direct mode with reset asserted: out follows D regardless.
    for (int i = 0; i < 5; i++) begin
      d0 = dir_d[i]; en0 = dir_en[i];
      #2;
      check($sformatf("dir_rst0_%0d", i), out0, dir_d[i]);
    end
    // Direct mode with reset released.
    rst0 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      d0 = dir2_d[i]; en0 = ~dir_en[i];
      #2;
      check($sformatf("dir_rst1_%0d", i), out0, dir2_d[i]);
    end

    // Registered mode: reset at first edge.
    @(negedge clk);
    rst1 = 1'b0; en1 = 1'b1; d1 = 18'h3FFFF;
    tick();
    check("pipe_reset", out1, 18'h00000);

    // Load 2A5A5; before the edge out still shows the prior value.
    @(negedge clk);
    rst1 = 1'b1; en1 = 1'b1; d1 = 18'h2A5A5;
    #1;
    check("pipe_pre_edge", out1, 18'h00000);
    tick();
    check("pipe_load", out1, 18'h2A5A5);

    // D changing between edges does not reach out.
    d1 = 18'h11111;
    #2;
    check("pipe_mid_d", out1, 18'h2A5A5);

    // Load 00123 then hold for 3 edges with enable low.
    @(negedge clk);
    d1 = 18'h00123; en1 = 1'b1;
    tick();
    check("pipe_load2", out1, 18'h00123);
    @(negedge clk);
    en1 = 1'b0; d1 = 18'h3FFFF;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("pipe_hold_%0d", i), out1, 18'h00123);
    end

    // Reset asserted mid-cycle: no effect until the edge, then clears despite enable.
    @(negedge clk);
    rst1 = 1'b0; en1 = 1'b1; d1 = 18'h15555;
    #1;
    check("pipe_rst_mid", out1, 18'h00123);
    tick();
    check("pipe_rst_edge", out1, 18'h00000);

    // Release reset with enable low: stays zero.
    @(negedge clk);
    rst1 = 1'b1; en1 = 1'b0; d1 = 18'h15555;
    tick();
    check("pipe_release", out1, 18'h00000);
    tick();
    check("pipe_release2", out1, 18'h00000);

    // First load after release.
    @(negedge clk);
    en1 = 1'b1; d1 = 18'h00001;
    tick();
    check("pipe_first_load", out1, 18'h00001);

    // Direct instance still tracks D while the clock runs.
    d0 = 18'h2BCDE;
    #2;
    check("dir_clocked", out0, 18'h2BCDE);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
